// File: rtl/img_sram_pkg.sv
// rtl/img_sram_pkg.sv - shared state, mode and skid-buffer definitions for the image SRAM transfer block
package img_sram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      TX,
      DRAIN,
      DONE
   } io_xfer_state_t;

   localparam logic MODE_RX    = 1'b0;
   localparam logic MODE_TX    = 1'b1;
   localparam int   SKID_DEPTH = 2;

   // Beats the TX path owes downstream: buffered entries plus the read still in the SRAM pipe.
   function automatic logic [2:0] skid_items(input logic [1:0] count, input logic pending);
      return {1'b0, count} + {2'b00, pending};
   endfunction

endpackage

// File: rtl/io_skid_buf.sv
// rtl/io_skid_buf.sv - two-entry fall-through skid buffer between SRAM read data and the TX stream
module io_skid_buf #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic              push;
   logic              pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0) || in_valid;

   // An empty buffer passes input straight through, so a read lands on the stream the cycle it returns.
   always_comb begin
      out_data = '0;
      if (count != 2'd0) begin
         out_data = mem[rd_ptr];
      end else if (in_valid) begin
         out_data = in_data;
      end
   end

   assign push = in_valid && in_ready && !((count == 2'd0) && out_ready);
   assign pop  = (count != 2'd0) && out_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (flush) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/io_xfer_controller.sv
// rtl/io_xfer_controller.sv - moves an nrows x ncols image between a pixel stream and a word SRAM
module io_xfer_controller
   import img_sram_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 14,
   parameter int DIM_W  = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              mode,
   input  logic              abort,
   input  logic [DIM_W-1:0]  nrows,
   input  logic [DIM_W-1:0]  ncols,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   localparam int               CNT_W   = 2 * DIM_W;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   io_xfer_state_t    state;
   logic [CNT_W-1:0]  total;
   logic [CNT_W-1:0]  beat_cnt;
   logic [ADDR_W-1:0] addr;
   logic              rd_pending;
   logic              rx_beat;
   logic              rd_issue;
   logic              last_beat;
   logic              drain_exit;
   logic              flush;
   logic              buf_in_ready;
   logic [1:0]        buf_count;
   logic [2:0]        items;

   assign busy    = (state == RX) || (state == TX) || (state == DRAIN);
   assign done    = (state == DONE);
   assign s_ready = (state == RX);
   assign flush   = abort && busy;

   assign items     = skid_items(buf_count, rd_pending);
   assign last_beat = (beat_cnt == total - CNT_ONE);
   assign rx_beat   = s_ready && s_valid;
   // A read is only issued when its data is guaranteed a slot, since returning data cannot be stalled.
   assign rd_issue  = (state == TX) && buf_in_ready && (items < 3'(SKID_DEPTH));
   assign drain_exit = (items == 3'd0) || ((items == 3'd1) && m_ready);

   assign sram_en    = rx_beat || rd_issue;
   assign sram_we    = rx_beat;
   assign sram_addr  = sram_en ? addr : '0;
   assign sram_wdata = rx_beat ? s_data : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         total      <= '0;
         beat_cnt   <= '0;
         addr       <= '0;
         rd_pending <= 1'b0;
         err        <= 1'b0;
      end else begin
         err        <= 1'b0;
         rd_pending <= rd_issue && !flush;
         if (flush) begin
            state    <= IDLE;
            beat_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if ((nrows == '0) || (ncols == '0)) begin
                        err <= 1'b1;
                     end else begin
                        total    <= CNT_W'(nrows) * CNT_W'(ncols);
                        beat_cnt <= '0;
                        addr     <= base_addr;
                        state    <= (mode == MODE_TX) ? TX : RX;
                     end
                  end
               end
               RX: begin
                  if (rx_beat) begin
                     beat_cnt <= beat_cnt + CNT_ONE;
                     addr     <= addr + ADDR_W'(1);
                     if (last_beat) begin
                        state <= DONE;
                     end
                  end
               end
               TX: begin
                  if (rd_issue) begin
                     beat_cnt <= beat_cnt + CNT_ONE;
                     addr     <= addr + ADDR_W'(1);
                     if (last_beat) begin
                        state <= DRAIN;
                     end
                  end
               end
               DRAIN: begin
                  if (drain_exit) begin
                     state <= DONE;
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   io_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .in_valid  (rd_pending),
      .in_ready  (buf_in_ready),
      .in_data   (sram_rdata),
      .out_valid (m_valid),
      .out_ready (m_ready),
      .out_data  (m_data),
      .count     (buf_count)
   );

endmodule

// File: doc/io_xfer_controller.md
IO_XFER_CONTROLLER -- requirements
Module: io_xfer_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pixel width in bits.
REQ-002 SHALL have parameter ADDR_W, default 14: SRAM word-address width.
REQ-003 SHALL have parameter DIM_W, default 8: width of nrows and ncols.
REQ-004 SHALL have port clk  in  1: single clock, all logic on rising edge.
REQ-005 SHALL have port rstn  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1: begin a transfer (sampled in IDLE only).
REQ-007 SHALL have port mode  in  1: 0 = RX (stream to SRAM), 1 = TX (SRAM to stream); sampled with start.
REQ-008 SHALL have port abort  in  1: synchronous cancel of the active transfer.
REQ-009 SHALL have ports nrows, ncols  in  DIM_W each: image dimensions; sampled with start.
REQ-010 SHALL have port base_addr  in  ADDR_W: first SRAM word; sampled with start.
REQ-011 SHALL have ports s_valid in 1, s_ready out 1, s_data in DATA_W: RX input stream.
REQ-012 SHALL have ports m_valid out 1, m_ready in 1, m_data out DATA_W: TX output stream.
REQ-013 SHALL have ports busy out 1, done out 1 (one-cycle pulse), err out 1 (one-cycle pulse).
REQ-014 SHALL have ports sram_en out 1, sram_we out 1, sram_addr out ADDR_W, sram_wdata out DATA_W, sram_rdata in DATA_W (1-cycle synchronous read latency).

Function
REQ-015 SHALL implement states IDLE, RX, TX, DRAIN, DONE.
REQ-016 IDLE: on start, latch mode/dims/base; total = nrows*ncols (2*DIM_W bits, no truncation); go to RX or TX next cycle.
REQ-017 start with nrows==0 or ncols==0: err pulse next cycle, stay IDLE, no SRAM access.
REQ-018 start while not IDLE SHALL be ignored.
REQ-019 busy SHALL be 1 in RX, TX, DRAIN; 0 in IDLE and DONE.
REQ-020 Address of beat i = (base_addr + i) mod 2^ADDR_W; wrap-around permitted, no error.
REQ-021 RX: s_ready=1; each cycle with s_valid&&s_ready drives sram_en=1, sram_we=1, sram_addr, sram_wdata=s_data combinationally in that cycle.
REQ-022 RX: after beat total-1 accepted, s_ready=0 next cycle and state = DONE.
REQ-023 TX: read issued (sram_en=1, sram_we=0) whenever reads remain and the 2-entry output skid buffer has a free slot counting the in-flight read.
REQ-024 TX: first m_valid SHALL assert the second cycle after start is sampled; with m_ready held 1, one beat per cycle sustained.
REQ-025 TX: m_valid && !m_ready SHALL hold m_data and m_valid stable; no beat lost or duplicated.
REQ-026 TX: after last read issued, state = DRAIN until the buffer empties; then DONE.
REQ-027 DONE SHALL last exactly one cycle with done=1, then IDLE.
REQ-028 abort in RX/TX/DRAIN: next cycle IDLE, buffer flushed, m_valid=0, s_ready=0, no done; in-flight read data discarded.
REQ-029 abort and start in the same IDLE cycle: start wins (abort ignored in IDLE).
REQ-030 sram_en=0 in IDLE, DRAIN, DONE; sram_we=0 outside RX.

Reset
REQ-031 rstn low SHALL asynchronously force IDLE, counters 0, buffer empty, and s_ready, m_valid, busy, done, err, sram_en, sram_we = 0; sram_addr, sram_wdata, m_data = 0.
REQ-032 Reset mid-transfer SHALL abandon it without done; first start after release is honoured.

Structure
REQ-033 State enum io_xfer_state_t and mode constants MODE_RX/MODE_TX SHALL live in img_sram_pkg.
REQ-034 The skid buffer SHALL be sub-module io_skid_buf (parameter DATA_W, depth 2, valid/ready both sides).
REQ-035 Top SHALL fit 120-400 RTL lines; no multi-cycle multipliers (product computed once at start).

Verification
REQ-036 RX 128x128, base 0, s_valid always 1, data = i mod 256 -> 16384 writes, addr 0..16383, done 16385 cycles after start.
REQ-037 TX 128x128, base 0, m_ready always 1 -> m_valid 2 cycles after start, 16384 consecutive beats equal to SRAM contents, then done.
REQ-038 TX 4x4, m_ready toggling 1,0,0,1 -> exactly 16 beats in order, m_data stable during stalls.
REQ-039 RX 2x3, base 2^14-2 -> addresses 16382, 16383, 0, 1, 2, 3.
REQ-040 start with nrows=0 -> err pulse, busy stays 0, no sram_en.
REQ-041 abort at beat 5 of TX 8x8, then rstn pulse mid RX 8x8 -> IDLE, no done, all outputs at reset values; next TX 2x2 completes normally.
